screen_fill: RTL and testbench

Full-screen fill engine that services the splash/game-state controller's draw requests (black clear, red game-over, title screen). It sweeps every pixel of the VGA framebuffer in raster order and drives the adapter's x/y/colour/plot write port, one pixel per cycle. When a sweep finishes it returns a one-cycle completion pulse, so the controller can leave its draw state.

---
 rtl/snake_pkg.sv | 19 +
 rtl/raster_counter.sv | 42 ++++
 rtl/screen_fill.sv | 121 ++++++++++++
 tb/tb_screen_fill.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game video path.
// Colours, fill kinds and default screen dimensions.
package snake_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    FILL_BLACK = 2'd0,
    FILL_RED   = 2'd1,
    FILL_TITLE = 2'd2
  } fill_kind_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter for full-screen sweeps.
// Wraps at WIDTH-1 / HEIGHT-1; synchronous clear.
module raster_counter
  import snake_pkg::*;
#(
  parameter int WIDTH  = SCR_W,
  parameter int HEIGHT = SCR_H,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/screen_fill.sv
// Full-screen fill engine: raster sweep with plot strobe and done pulse.
// Define SCREEN_FILL_CHECKER_EN for an 8x8 checkerboard title fill.
module screen_fill
  import snake_pkg::*;
#(
  parameter int WIDTH  = SCR_W,
  parameter int HEIGHT = SCR_H,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_black,
  input  logic          req_red,
  input  logic          req_title,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE,
    RELEASE
  } state_t;

  state_t     state, state_nxt;
  fill_kind_t kind, kind_nxt;
  logic       any_req;
  logic       cnt_clr;
  logic       cnt_en;
  logic       last;

  assign any_req = req_black | req_red | req_title;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_raster (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .x   (x),
    .y   (y),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kind  <= FILL_BLACK;
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    plot      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (any_req) begin
          state_nxt = SWEEP;
          if (req_red)
            kind_nxt = FILL_RED;
          else if (req_black)
            kind_nxt = FILL_BLACK;
          else
            kind_nxt = FILL_TITLE;
        end
      end
      SWEEP: begin
        plot   = 1'b1;
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!any_req)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Colour follows the live coordinates so it lines up with plot.
  always_comb begin
    colour = COL_BLACK;
    unique case (kind)
      FILL_BLACK: colour = COL_BLACK;
      FILL_RED:   colour = COL_RED;
      FILL_TITLE: begin
`ifdef SCREEN_FILL_CHECKER_EN
        colour = (x[3] ^ y[3]) ? COL_WHITE : COL_BLUE;
`else
        colour = COL_BLUE;
`endif
      end
      default:    colour = COL_BLACK;
    endcase
  end

endmodule

// File: tb/tb_screen_fill.sv
// Directed testbench for screen_fill.
// Inputs change just after rising edges; outputs sampled on falling edges.
module tb_screen_fill;

  logic       clk;
  logic       rst;
  logic       req_black;
  logic       req_red;
  logic       req_title;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int total;
  int bad;

  screen_fill dut (
    .clk      (clk),
    .rst      (rst),
    .req_black(req_black),
    .req_red  (req_red),
    .req_title(req_title),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 black, 1 red, 2 title
  function automatic logic [2:0] exp_col(input int kind, input int px, input int py);
    if (kind == 0) return 3'b000;
    if (kind == 1) return 3'b100;
`ifdef SCREEN_FILL_CHECKER_EN
    if ((((px / 8) + (py / 8)) % 2) == 1) return 3'b111;
`endif
    return 3'b001;
  endfunction

  task automatic set_req(input logic b, input logic r, input logic t);
    @(posedge clk);
    #1;
    req_black = b;
    req_red   = r;
    req_title = t;
  endtask

  task automatic collect(input int kind, input int drop_px,
                         output int plots, output int col_bad,
                         output int ord_bad, output int dones,
                         output int first_cyc,
                         output int last_x, output int last_y);
    int ex;
    int ey;
    ex = 0; ey = 0;
    plots = 0; col_bad = 0; ord_bad = 0; dones = 0;
    first_cyc = -1; last_x = -1; last_y = -1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (plot) begin
        if (first_cyc < 0) first_cyc = c;
        if (x !== 8'(ex) || y !== 7'(ey)) ord_bad++;
        if (colour !== exp_col(kind, int'(x), int'(y))) col_bad++;
        last_x = int'(x);
        last_y = int'(y);
        plots++;
        ex++;
        if (ex == 160) begin ex = 0; ey++; end
        if (plots == drop_px) begin
          req_black = 1'b0;
          req_red   = 1'b0;
          req_title = 1'b0;
        end
      end
      if (done) begin
        dones++;
        if (plot || !busy) ord_bad++;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_black = 1'b0; req_red = 1'b0; req_title = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({x, y, colour, plot, busy, done} !== 21'd0) begin
      bad++;
      $display("FAIL reset_vals got x=%0d y=%0d c=%b p=%b b=%b d=%b want zeros",
               x, y, colour, plot, busy, done);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet got p=%b b=%b want 0 0", plot, busy);
    end
  endtask

  task automatic test_black;
    int pl, cb, ob, dn, fc, lx, ly;
    set_req(1'b1, 1'b0, 1'b0);
    collect(0, -1, pl, cb, ob, dn, fc, lx, ly);
    total++;
    if (pl !== 19200) begin bad++; $display("FAIL black_plots got %0d want 19200", pl); end
    total++;
    if (cb !== 0) begin bad++; $display("FAIL black_colour got %0d bad want 0", cb); end
    total++;
    if (ob !== 0) begin bad++; $display("FAIL black_order got %0d bad want 0", ob); end
    total++;
    if (fc !== 1) begin bad++; $display("FAIL black_latency got %0d want 1", fc); end
    total++;
    if (lx !== 159 || ly !== 119) begin
      bad++; $display("FAIL black_last got (%0d,%0d) want (159,119)", lx, ly);
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL black_done got %0d want 1", dn); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL black_after got d=%b b=%b p=%b want 0 0 0", done, busy, plot);
    end
    req_black = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_title_hold;
    int pl, cb, ob, dn, fc, lx, ly;
    int viol;
    set_req(1'b0, 1'b0, 1'b1);
    collect(2, -1, pl, cb, ob, dn, fc, lx, ly);
    total++;
    if (pl !== 19200 || dn !== 1) begin
      bad++; $display("FAIL title_sweep got plots=%0d dones=%0d want 19200 1", pl, dn);
    end
    total++;
    if (cb !== 0 || ob !== 0) begin
      bad++; $display("FAIL title_pixels got colbad=%0d ordbad=%0d want 0 0", cb, ob);
    end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (plot || busy || done) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL title_release got %0d active want 0", viol); end
    req_title = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_red_priority_drop;
    int pl, cb, ob, dn, fc, lx, ly;
    set_req(1'b0, 1'b1, 1'b1);
    collect(1, 500, pl, cb, ob, dn, fc, lx, ly);
    total++;
    if (fc !== 1) begin bad++; $display("FAIL red_latency got %0d want 1", fc); end
    total++;
    if (cb !== 0) begin bad++; $display("FAIL red_colour got %0d bad want 0", cb); end
    total++;
    if (pl !== 19200 || ob !== 0) begin
      bad++; $display("FAIL red_drop got plots=%0d ordbad=%0d want 19200 0", pl, ob);
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL red_done got %0d want 1", dn); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int found;
    int pl, cb, ob;
    set_req(1'b1, 1'b0, 1'b0);
    found = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (plot && x == 8'd40 && y == 7'd60) begin found = 1; break; end
    end
    total++;
    if (found !== 1) begin bad++; $display("FAIL rst_reach got %0d want 1", found); end
    rst = 1'b0;
    req_black = 1'b0;
    #1;
    total++;
    if ({x, y, colour, plot, busy, done} !== 21'd0) begin
      bad++;
      $display("FAIL rst_async got x=%0d y=%0d c=%b p=%b b=%b d=%b want zeros",
               x, y, colour, plot, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL rst_nodone got %b want 0", done); end
    set_req(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    pl = 0; cb = 0; ob = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!plot) ob++;
      if (x !== 8'(i % 160) || y !== 7'(i / 160)) ob++;
      if (colour !== exp_col(2, i % 160, i / 160)) cb++;
      pl++;
    end
    total++;
    if (ob !== 0) begin bad++; $display("FAIL rst_restart_order got %0d bad want 0", ob); end
    total++;
    if (cb !== 0) begin bad++; $display("FAIL rst_restart_colour got %0d bad want 0", cb); end
    rst = 1'b0;
    req_title = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_black();
    test_title_hold();
    test_red_priority_drop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
